// File: rtl/sm_muldiv_pkg.sv
// Shared op codes, funct/ALU constants and FSM state type for the schoolMIPS
// multiply/divide unit.
package sm_muldiv_pkg;

  localparam logic [2:0] MD_OP_MULTU = 3'd0;
  localparam logic [2:0] MD_OP_MULT  = 3'd1;
  localparam logic [2:0] MD_OP_DIVU  = 3'd2;
  localparam logic [2:0] MD_OP_DIV   = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam logic [3:0] ALU_MFHI = 4'd8;
  localparam logic [3:0] ALU_MFLO = 4'd9;

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} md_state_e;

  // MULTU/MULT/DIVU/DIV occupy codes 0..3 and are the only ones that run the FSM.
  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift/compare/subtract
// for divide. Purely combinational.
module sm_muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   top;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  // Divide: remainder shifted left with the next dividend bit; needs a carry bit.
  assign top  = acc[2*WIDTH-1:WIDTH-1];
  assign diff = top[WIDTH-1:0] - operand;
  // Multiply: conditionally add multiplicand into the upper half, then shift right.
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & operand};

  always_comb begin
    acc_next = '0;
    if (is_div) begin
      if (top >= {1'b0, operand}) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers and a start/busy/done
// handshake; one result bit per cycle plus a prep and a sign-fix cycle.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, operand_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [CW-1:0]      cnt_q;
  logic               neg_quo_q, neg_rem_q, mt_done_q;

  logic               is_div, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, hi_fix, lo_fix;

  // op_q[1] selects divide, op_q[0] selects signed.
  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;

  sm_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div  (is_div),
    .acc     (acc_q),
    .operand (operand_q),
    .acc_next(acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start && is_muldiv_op(op)) state_d = StPrep;
        StPrep:  state_d = StCalc;
        StCalc:  if (cnt_q == '0) state_d = StFix;
        StFix:   state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone) | mt_done_q;
  end

  // Divide by zero bypasses the sign fix and reports the raw dividend in HI.
  always_comb begin
    hi_fix = acc_q[2*WIDTH-1:WIDTH];
    lo_fix = acc_q[WIDTH-1:0];
    if (!is_div) begin
      if (neg_quo_q) {hi_fix, lo_fix} = -acc_q;
    end else if (b_q == '0) begin
      hi_fix = a_q;
      lo_fix = '1;
    end else begin
      if (neg_quo_q) lo_fix = -acc_q[WIDTH-1:0];
      if (neg_rem_q) hi_fix = -acc_q[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mt_done_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      mt_done_q <= 1'b0;
      if (!abort) begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              op_q <= op[1:0];
              a_q  <= srcA;
              b_q  <= srcB;
              if (op == MD_OP_MTHI) begin
                hi_q      <= srcA;
                mt_done_q <= 1'b1;
              end else if (op == MD_OP_MTLO) begin
                lo_q      <= srcA;
                mt_done_q <= 1'b1;
              end
            end
          end
          StPrep: begin
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= CW'(WIDTH - 1);
            if (is_div) begin
              acc_q     <= {{WIDTH{1'b0}}, a_mag};
              operand_q <= b_mag;
            end else begin
              acc_q     <= {{WIDTH{1'b0}}, b_mag};
              operand_q <= a_mag;
            end
          end
          StCalc: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - 1'b1;
          end
          StFix: begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
          end
          default: ;
        endcase
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: doc/sm_muldiv.md
Name: sm_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the schoolMIPS core. It replaces the single-cycle combinational MUL in the ALU.
- Supports signed and unsigned MULT/DIV at parametrised width, plus MTHI/MTLO.
- Uses a start/busy/done handshake, so the CPU control stalls the PC while busy.
- Sits beside the ALU. Operands come from the register-file read ports; HI/LO feed MFHI/MFLO.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (must be ≥4, even).

Ports:
clk    input   1      clock; all state updates on rising edge
rst    input   1      synchronous active-high reset
start  input   1      request; accepted only when busy=0
op     input   3      MD_OP_MULTU/MULT/DIVU/DIV/MTHI/MTLO (sampled with start)
srcA   input   WIDTH  multiplicand / dividend / MTHI-MTLO data
srcB   input   WIDTH  multiplier / divisor
abort  input   1      cancel in-flight operation (exception flush)
busy   output  1      high while an operation is in flight
done   output  1      one-cycle pulse when HI/LO have just been updated
hi     output  WIDTH  HI register
lo     output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; internal accumulators cleared. Reset mid-operation discards the operation; HI/LO go to 0.
- FSM states and transitions:
  - IDLE: start=1 with MULT/DIV ops → PREP. Any other op code → ignored.
  - PREP (1 cycle): latch magnitudes. For signed ops, take the absolute value of each operand and record negQ=sA^sB and negR=sA. Unsigned ops: negQ=negR=0. Set counter=WIDTH-1 → CALC.
  - CALC (WIDTH cycles): one radix-2 step per cycle, counter decrements, counter==0 → FIX.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract; quotient bit=1 when partial remainder ≥ divisor.
  - FIX (1 cycle): apply sign correction and write HI/LO → DONE_ST.
  - DONE_ST (1 cycle): done=1 → IDLE.
- MTHI/MTLO: with start in IDLE, write srcA into hi/lo at the next edge. Do not enter the FSM. done pulses the cycle after the write edge; busy stays 0.
- Latency: start accepted at edge N. hi/lo update at edge N+WIDTH+2. done=1 in the cycle after that edge. busy=1 from edge N+1 through the done cycle. Next start may be accepted in the done cycle's following cycle (busy=0).
- start while busy=1: ignored, no queuing.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product. Signed product is negated in two's complement when negQ.
  - DIV/DIVU: lo=quotient, hi=remainder. Quotient truncates toward zero; remainder takes dividend's sign.
  - Signed most-negative / -1: lo=most-negative (wraps), hi=0.
- Divide by zero (signed or unsigned): sign fix bypassed; lo=all ones, hi=srcA as presented. Completes with normal latency.
- abort=1 in any state: next edge → IDLE, busy=0, hi/lo unchanged, no done pulse. abort takes priority over start in the same cycle. rst takes priority over abort.
- Operands are latched at acceptance; srcA/srcB/op may change while busy without effect.

Decomposition:
- Shared header sm_cpu.vh gets:
  - MD_OP_* codes (MULTU=0, MULT=1, DIVU=2, DIV=3, MTHI=4, MTLO=5).
  - F_MULT/F_MULTU/F_DIV/F_DIVU/F_MFHI/F_MFLO/F_MTHI/F_MTLO funct constants.
  - ALU_MFHI/ALU_MFLO selects for the core.
- One natural sub-module: sm_muldiv_step. It is combinational and performs one iteration: a shift-add for multiply, or a shift/compare/subtract for divide. It takes the accumulator and operand, a mode bit, and returns the next accumulator.
- FSM, counter, and sign fix stay in sm_muldiv.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles hi=0xFFFFFFFE, lo=0x00000001; done one cycle; busy width exact.
- MULT -7 × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Start DIVU 50/7, pulse abort at cycle 10 → busy falls next edge, no done, hi/lo keep prior values. A new start is then accepted and returns lo=7, hi=1.
- MTLO 0x1234 then MTHI 0xABCD back-to-back → lo=0x1234, hi=0xABCD, two done pulses, busy never high. A start during a running DIVU is ignored.
- WIDTH=8: MULT 0x80 × 0x80 → {hi,lo}=0x4000 in 10 cycles. Assert rst mid-CALC → hi=lo=0, busy=0 next cycle.
